// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rr_arb4_if.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__rr_arb4_if
// Brief    : Request/grant bundle between requesters and the round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface gf180mcu_fd_sc_mcu7t5v0__rr_arb4_if #(
   parameter int N   = 4,
   parameter int IDW = 2
);
   logic [N-1:0]   REQ;
   logic           LOCK;
   logic [N-1:0]   GNT;
   logic           GNT_VLD;
   logic [IDW-1:0] GNT_ID;

   modport master (
      output REQ,
      output LOCK,
      input  GNT,
      input  GNT_VLD,
      input  GNT_ID
   );

   modport slave (
      input  REQ,
      input  LOCK,
      output GNT,
      output GNT_VLD,
      output GNT_ID
   );
endinterface
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rr_arb4.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__rr_arb4
// Brief    : N-way round-robin arbiter, registered one-hot grant, hold limit
//            with LOCK override.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__rr_arb4 #(
   parameter int N        = 4,
   parameter int IDW      = 2,
   parameter int MAX_HOLD = 8
) (
   input  logic CLK,
   input  logic RST,
   gf180mcu_fd_sc_mcu7t5v0__rr_arb4_if.slave arb
);

   localparam int HW = (MAX_HOLD <= 1) ? 1 : $clog2(MAX_HOLD + 1);

   logic [N-1:0]   gnt_q,     gnt_d;
   logic           gnt_vld_q, gnt_vld_d;
   logic [IDW-1:0] gnt_id_q,  gnt_id_d;
   logic [IDW-1:0] ptr_q,     ptr_d;
   logic [HW-1:0]  hcnt_q,    hcnt_d;

   logic           win_vld;
   logic [IDW-1:0] win_id;
   logic           others_req;
   logic           hold_ok;
   logic           keep;
   logic           hcnt_below_max;

   // Descending scan so the smallest offset from ptr_q is the last write and wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         int             j;
         logic [IDW-1:0] cand;
         j = int'(ptr_q) + k;
         if (j >= N) j = j - N;
         cand = IDW'(j);
         if (arb.REQ[cand]) begin
            win_vld = 1'b1;
            win_id  = cand;
         end
      end
   end

   always_comb begin
      others_req     = |(arb.REQ & ~gnt_q);
      hcnt_below_max = (MAX_HOLD != 0) && (int'(hcnt_q) < MAX_HOLD - 1);
      hold_ok        = arb.LOCK || (MAX_HOLD == 0) || hcnt_below_max || !others_req;
      keep           = gnt_vld_q && arb.REQ[gnt_id_q] && hold_ok;
   end

   always_comb begin
      gnt_d     = gnt_q;
      gnt_vld_d = gnt_vld_q;
      gnt_id_d  = gnt_id_q;
      ptr_d     = ptr_q;
      hcnt_d    = hcnt_q;
      if (keep) begin
         if (hcnt_below_max) hcnt_d = hcnt_q + 1'b1;
      end else begin
         // Release and idle share one path: ptr_q already points past the owner.
         hcnt_d = '0;
         if (win_vld) begin
            gnt_d         = '0;
            gnt_d[win_id] = 1'b1;
            gnt_vld_d     = 1'b1;
            gnt_id_d      = win_id;
            ptr_d         = (int'(win_id) == N - 1) ? '0 : win_id + 1'b1;
         end else begin
            gnt_d     = '0;
            gnt_vld_d = 1'b0;
            gnt_id_d  = '0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         gnt_q     <= '0;
         gnt_vld_q <= 1'b0;
         gnt_id_q  <= '0;
         ptr_q     <= '0;
         hcnt_q    <= '0;
      end else begin
         gnt_q     <= gnt_d;
         gnt_vld_q <= gnt_vld_d;
         gnt_id_q  <= gnt_id_d;
         ptr_q     <= ptr_d;
         hcnt_q    <= hcnt_d;
      end
   end

   assign arb.GNT     = gnt_q;
   assign arb.GNT_VLD = gnt_vld_q;
   assign arb.GNT_ID  = gnt_id_q;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rr_arb4.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu7t5v0__rr_arb4
// Brief    : Directed self-checking bench for the round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu7t5v0__rr_arb4;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   gf180mcu_fd_sc_mcu7t5v0__rr_arb4_if #(.N(4), .IDW(2)) bus ();

   gf180mcu_fd_sc_mcu7t5v0__rr_arb4 #(
      .N        (4),
      .IDW      (2),
      .MAX_HOLD (8)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .arb (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [3:0] eg, input logic ev,
                        input logic [1:0] eid);
      vectors++;
      assert ({bus.GNT, bus.GNT_VLD, bus.GNT_ID} === {eg, ev, eid}) else begin
         miscompares++;
         $error("FAIL %s: observed gnt=%b vld=%b id=%0d, expected gnt=%b vld=%b id=%0d",
                tag, bus.GNT, bus.GNT_VLD, bus.GNT_ID, eg, ev, eid);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input logic [3:0] req, input logic lock);
      rst      = 1'b1;
      bus.REQ  = req;
      bus.LOCK = lock;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      bus.REQ     = 4'b0000;
      bus.LOCK    = 1'b0;

      // 1: reset state, then a lone requester keeps the grant indefinitely
      step(2);
      check("reset_state", 4'b0000, 1'b0, 2'd0);
      bus.REQ = 4'b0001;
      rst     = 1'b0;
      step(1);
      check("first_grant", 4'b0001, 1'b1, 2'd0);
      step(15);
      check("lone_hold", 4'b0001, 1'b1, 2'd0);

      // 2: all requesting, 8-cycle rotation with no bubble
      do_reset(4'b1111, 1'b0);
      for (int c = 0; c < 40; c++) begin
         step(1);
         check($sformatf("rotate_c%0d", c), 4'b0001 << ((c / 8) % 4), 1'b1,
               2'((c / 8) % 4));
      end

      // 3: owner drops, direct handover, then idle
      do_reset(4'b0101, 1'b0);
      step(1);
      check("drop_owner0", 4'b0001, 1'b1, 2'd0);
      bus.REQ = 4'b0100;
      step(1);
      check("handover_2", 4'b0100, 1'b1, 2'd2);
      bus.REQ = 4'b0000;
      step(1);
      check("go_idle", 4'b0000, 1'b0, 2'd0);

      // 4: LOCK overrides the hold limit, dropping it releases at once
      do_reset(4'b0011, 1'b1);
      for (int c = 0; c < 20; c++) begin
         step(1);
         check($sformatf("lock_c%0d", c), 4'b0001, 1'b1, 2'd0);
      end
      bus.LOCK = 1'b0;
      step(1);
      check("unlock_release", 4'b0010, 1'b1, 2'd1);

      // 5: pointer at 3 wraps to 0 before 1
      do_reset(4'b0100, 1'b0);
      step(1);
      check("grant_2", 4'b0100, 1'b1, 2'd2);
      bus.REQ = 4'b0011;
      step(1);
      check("wrap_to_0", 4'b0001, 1'b1, 2'd0);
      step(7);
      check("wrap_hold", 4'b0001, 1'b1, 2'd0);
      step(1);
      check("wrap_next_1", 4'b0010, 1'b1, 2'd1);

      // 6: asynchronous reset mid-cycle, then pointer back at 0
      do_reset(4'b0100, 1'b0);
      step(1);
      check("pre_async", 4'b0100, 1'b1, 2'd2);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", 4'b0000, 1'b0, 2'd0);
      bus.REQ = 4'b1100;
      step(1);
      rst = 1'b0;
      step(1);
      check("post_reset_grant", 4'b0100, 1'b1, 2'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
